// File: rtl/audio_mix_scheduler_if.sv
// rtl/audio_mix_scheduler_if.sv - voice poll bus and codec output handshake
interface audio_mix_scheduler_if #(
  parameter int NUM_VOICES = 4,
  parameter int W          = 16
) ();
  logic [NUM_VOICES-1:0] voice_req;
  logic                  voice_ack;
  logic [W-1:0]          voice_data;
  logic [W-1:0]          out_sample;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    output voice_req, out_sample, out_valid,
    input  voice_ack, voice_data, out_ready
  );

  modport slave (
    input  voice_req, out_sample, out_valid,
    output voice_ack, voice_data, out_ready
  );
endinterface

// File: rtl/audio_mix_scheduler.sv
// rtl/audio_mix_scheduler.sv - sample-rate divider, voice poller and saturating mixer
module audio_mix_scheduler #(
  parameter int DIV        = 32,
  parameter int NUM_VOICES = 4,
  parameter int W          = 16,
  parameter int TIMEOUT    = 4
) (
  input  logic                   in_clk,
  input  logic                   resetn,
  input  logic                   enable,
  input  logic [NUM_VOICES-1:0]  voice_mute,
  audio_mix_scheduler_if.master  bus,
  output logic                   tick,
  output logic                   overrun,
  output logic                   timeout
);
  localparam int CW = $clog2(DIV);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int AW = W + 3;
  localparam logic signed [AW-1:0] MAX_V = {4'b0000, {(W-1){1'b1}}};
  localparam logic signed [AW-1:0] MIN_V = {4'b1111, {(W-1){1'b0}}};
  localparam logic [2:0] LAST_IDX = 3'(NUM_VOICES - 1);

  typedef enum logic [1:0] {IDLE, REQ, SAT, OUT} state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [2:0]             idx_q, idx_d;
  logic [TW-1:0]          wait_q, wait_d;
  logic signed [AW-1:0]   acc_q, acc_d;
  logic [NUM_VOICES-1:0]  voice_req_q, voice_req_d;
  logic [W-1:0]           out_sample_q, out_sample_d;
  logic                   out_valid_q, out_valid_d;
  logic                   overrun_q, overrun_d;
  logic                   timeout_q, timeout_d;
  logic                   advance;

  // A muted voice gets no request; REQ treats an empty request as "skip".
  function automatic logic [NUM_VOICES-1:0] req_for(input logic [2:0] i,
                                                    input logic [NUM_VOICES-1:0] m);
    logic [NUM_VOICES-1:0] oh;
    oh = '0;
    for (int k = 0; k < NUM_VOICES; k++) begin
      if (i == 3'(k)) oh[k] = !m[k];
    end
    return oh;
  endfunction

  assign tick           = enable && (cnt_q == CW'(DIV - 1));
  assign bus.voice_req  = voice_req_q;
  assign bus.out_sample = out_sample_q;
  assign bus.out_valid  = out_valid_q;
  assign overrun        = overrun_q;
  assign timeout        = timeout_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = '0;
    idx_d        = idx_q;
    wait_d       = wait_q;
    acc_d        = acc_q;
    voice_req_d  = voice_req_q;
    out_sample_d = out_sample_q;
    out_valid_d  = out_valid_q;
    overrun_d    = overrun_q | (tick && (state_q != IDLE));
    timeout_d    = timeout_q;
    advance      = 1'b0;

    if (enable) cnt_d = (cnt_q == CW'(DIV - 1)) ? '0 : cnt_q + CW'(1);

    case (state_q)
      IDLE: begin
        if (tick) begin
          acc_d       = '0;
          idx_d       = '0;
          wait_d      = '0;
          voice_req_d = req_for(3'd0, voice_mute);
          state_d     = REQ;
        end
      end
      REQ: begin
        if (voice_req_q == '0) begin
          advance = 1'b1;
        end else if (bus.voice_ack) begin
          acc_d   = acc_q + {{3{bus.voice_data[W-1]}}, bus.voice_data};
          advance = 1'b1;
        end else if (wait_q == TW'(TIMEOUT)) begin
          timeout_d = 1'b1;
          advance   = 1'b1;
        end else begin
          wait_d = wait_q + TW'(1);
        end
        if (advance) begin
          wait_d = '0;
          if (idx_q == LAST_IDX) begin
            voice_req_d = '0;
            state_d     = SAT;
          end else begin
            idx_d       = idx_q + 3'd1;
            voice_req_d = req_for(idx_q + 3'd1, voice_mute);
          end
        end
      end
      SAT: begin
        if (acc_q > MAX_V)      out_sample_d = MAX_V[W-1:0];
        else if (acc_q < MIN_V) out_sample_d = MIN_V[W-1:0];
        else                    out_sample_d = acc_q[W-1:0];
        out_valid_d = 1'b1;
        state_d     = OUT;
      end
      OUT: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge in_clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      wait_q       <= '0;
      acc_q        <= '0;
      voice_req_q  <= '0;
      out_sample_q <= '0;
      out_valid_q  <= 1'b0;
      overrun_q    <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      wait_q       <= wait_d;
      acc_q        <= acc_d;
      voice_req_q  <= voice_req_d;
      out_sample_q <= out_sample_d;
      out_valid_q  <= out_valid_d;
      overrun_q    <= overrun_d;
      timeout_q    <= timeout_d;
    end
  end
endmodule
